// File: rtl/maze_renderer.sv
// maze_renderer: draws a COLS x ROWS maze grid with a blinking player marker (goal fill when MAZE_RENDERER_GOAL_EN is defined).
// Latency: fixed 2 cycles from pix_valid to pix_out_valid.
// Backpressure: none; one request per cycle, oled_data holds its last value between valid outputs.
module maze_renderer #(
    parameter int COLS         = 5,
    parameter int ROWS         = 4,
    parameter int CELL         = 15,
    parameter int X0           = 10,
    parameter int Y0           = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_begin,
    input  logic                     pix_valid,
    input  logic [6:0]               x,
    input  logic [6:0]               y,
    input  logic [ROWS*(COLS-1)-1:0] walls_v,
    input  logic [(ROWS-1)*COLS-1:0] walls_h,
    input  logic [5:0]               position,
    input  logic [5:0]               goal,
    output logic [15:0]              oled_data,
    output logic                     pix_out_valid
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam int MARGIN = 3;

    typedef enum logic {BLINK_ON = 1'b0, BLINK_OFF = 1'b1} blink_t;

    function automatic int xv(input int k);
        return X0 + k * CELL;
    endfunction

    function automatic int yh(input int k);
        return Y0 + k * CELL;
    endfunction

    // Per-frame snapshot of the maze state, so a frame never tears.
    logic [ROWS*(COLS-1)-1:0] sh_walls_v;
    logic [(ROWS-1)*COLS-1:0] sh_walls_h;
    logic [5:0]               sh_position;
    blink_t                   blink;
    logic [CW-1:0]            frame_cnt;

    int xi;
    int yi;
    assign xi = {25'd0, x};
    assign yi = {25'd0, y};

    // Stage-1 classification results
    logic       in_x, in_y, on_v, on_h;
    logic       black_hit, seg_hit, seg_closed, cell_hit;
    logic [5:0] cell_idx;
    logic       marker_hit, goal_hit;

    // Geometry: range comparisons against line coordinates, no division.
    always_comb begin
        in_x       = (xi >= X0) && (xi <= xv(COLS));
        in_y       = (yi >= Y0) && (yi <= yh(ROWS));
        on_v       = 1'b0;
        on_h       = 1'b0;
        seg_hit    = 1'b0;
        seg_closed = 1'b0;
        cell_hit   = 1'b0;
        cell_idx   = '0;
        for (int k = 0; k <= COLS; k++)
            if (xi == xv(k)) on_v = 1'b1;
        for (int k = 0; k <= ROWS; k++)
            if (yi == yh(k)) on_h = 1'b1;
        // Interior vertical segments: line k between rows
        for (int r = 0; r < ROWS; r++)
            for (int k = 1; k < COLS; k++)
                if (xi == xv(k) && yi > yh(r) && yi < yh(r + 1)) begin
                    seg_hit    = 1'b1;
                    seg_closed = sh_walls_v[r*(COLS-1) + k - 1];
                end
        // Interior horizontal segments: line k between columns
        for (int k = 1; k < ROWS; k++)
            for (int c = 0; c < COLS; c++)
                if (yi == yh(k) && xi > xv(c) && xi < xv(c + 1)) begin
                    seg_hit    = 1'b1;
                    seg_closed = sh_walls_h[(k-1)*COLS + c];
                end
        // Cell interiors at least MARGIN pixels from every line
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (xi >= xv(c) + MARGIN && xi <= xv(c + 1) - MARGIN &&
                    yi >= yh(r) + MARGIN && yi <= yh(r + 1) - MARGIN) begin
                    cell_hit = 1'b1;
                    cell_idx = 6'(r * COLS + c);
                end
        black_hit  = (on_v && in_y && (xi == X0 || xi == xv(COLS))) ||
                     (on_h && in_x && (yi == Y0 || yi == yh(ROWS))) ||
                     (on_v && on_h);
        // Out-of-range indices never equal a real cell index, so they draw nothing.
        marker_hit = cell_hit && (cell_idx == sh_position) && (blink == BLINK_ON);
    end

`ifdef MAZE_RENDERER_GOAL_EN
    logic [5:0] sh_goal;
    assign goal_hit = cell_hit && (cell_idx == sh_goal);

    // Goal snapshot taken with the rest of the maze state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         sh_goal <= '0;
        else if (frame_begin) sh_goal <= goal;
    end
`else
    logic unused_goal;
    assign unused_goal = ^goal;
    assign goal_hit    = 1'b0;
`endif

    // Shadow capture at frame start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_walls_v  <= '0;
            sh_walls_h  <= '0;
            sh_position <= '0;
        end else if (frame_begin) begin
            sh_walls_v  <= walls_v;
            sh_walls_h  <= walls_h;
            sh_position <= position;
        end
    end

    // Blink FSM: toggles every BLINK_FRAMES frames, restarts ON when the player moves
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink     <= BLINK_ON;
            frame_cnt <= '0;
        end else if (frame_begin) begin
            if (position != sh_position || BLINK_FRAMES == 0) begin
                blink     <= BLINK_ON;
                frame_cnt <= '0;
            end else if (frame_cnt == CNT_LAST) begin
                blink     <= (blink == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Stage 1 registers: classification flags computed from pre-update shadows
    logic s1_valid, s1_black, s1_seg, s1_closed, s1_marker, s1_goal;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_black  <= 1'b0;
            s1_seg    <= 1'b0;
            s1_closed <= 1'b0;
            s1_marker <= 1'b0;
            s1_goal   <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_black  <= black_hit;
            s1_seg    <= seg_hit;
            s1_closed <= seg_closed;
            s1_marker <= marker_hit;
            s1_goal   <= goal_hit;
        end
    end

    // Colour priority: border/intersection, wall segment, marker, goal, background
    logic [15:0] colour;
    always_comb begin
        colour = 16'hFFFF;
        if (s1_black)       colour = 16'h0000;
        else if (s1_seg)    colour = s1_closed ? 16'h0000 : 16'hFFFF;
        else if (s1_marker) colour = 16'hF800;
        else if (s1_goal)   colour = 16'h07E0;
    end

    // Stage 2 output register; data holds while no valid pixel is in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oled_data     <= '0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out_valid <= s1_valid;
            if (s1_valid) oled_data <= colour;
        end
    end

endmodule

// File: tb/tb_maze_renderer.sv
// tb_maze_renderer: directed vectors for maze_renderer with a queue scoreboard.
// Latency: expects each pixel exactly 2 cycles after request.
// Backpressure: none; monitor pops on every pix_out_valid.
module tb_maze_renderer;

    localparam int COLS = 5;
    localparam int ROWS = 4;

`ifdef MAZE_RENDERER_GOAL_EN
    localparam logic [15:0] GOAL_COL = 16'h07E0;
`else
    localparam logic [15:0] GOAL_COL = 16'hFFFF;
`endif

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     frame_begin = 1'b0;
    logic                     pix_valid = 1'b0;
    logic [6:0]               x = '0;
    logic [6:0]               y = '0;
    logic [ROWS*(COLS-1)-1:0] walls_v = '0;
    logic [(ROWS-1)*COLS-1:0] walls_h = '0;
    logic [5:0]               position = '0;
    logic [5:0]               goal = '0;
    logic [15:0]              oled_data;
    logic                     pix_out_valid;

    maze_renderer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_begin   (frame_begin),
        .pix_valid     (pix_valid),
        .x             (x),
        .y             (y),
        .walls_v       (walls_v),
        .walls_h       (walls_h),
        .position      (position),
        .goal          (goal),
        .oled_data     (oled_data),
        .pix_out_valid (pix_out_valid)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    string       name_q[$];
    logic [15:0] last_data = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pixel, checks colour and latency
    always @(negedge clock) begin
        if (!reset_n) begin
            last_data = 16'h0000;
        end else if (pix_out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pixel: got 0x%0h, expected no output", oled_data);
            end else begin
                logic [15:0] e;
                int          ec;
                string       nm;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, int'(oled_data), int'(e));
                chk({nm, "_latency"}, cyc, ec + 2);
            end
            last_data = oled_data;
        end else begin
            chk("hold", int'(oled_data), int'(last_data));
        end
    end

    task automatic pix(input int px, input int py, input logic [15:0] e, input string nm);
        x         = 7'(px);
        y         = 7'(py);
        pix_valid = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        name_q.push_back(nm);
        @(posedge clock); #1;
        pix_valid = 1'b0;
    endtask

    // Pixel requested in the same cycle as frame_begin
    task automatic pix_frame(input int px, input int py, input logic [15:0] e, input string nm);
        frame_begin = 1'b1;
        pix(px, py, e, nm);
        frame_begin = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_begin = 1'b1;
            @(posedge clock); #1;
            frame_begin = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("reset_valid", int'(pix_out_valid), 0);
        chk("reset_data", int'(oled_data), 0);
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Basic geometry, all walls open
        frames(1);
        pix(10, 30, 16'h0000, "left_border");
        pix(50, 30, 16'hFFFF, "cell_bg");
        pix(25, 17, 16'h0000, "intersection");
        pix(5, 5, 16'hFFFF, "outside_grid");
        pix(30, 17, 16'hFFFF, "open_h_seg");
        pix(85, 40, 16'h0000, "right_border");
        pix(60, 62, 16'h0000, "bottom_border");
        // Marker in cell 0, margin edges
        pix(13, 8, 16'hF800, "marker_edge_in");
        pix(12, 8, 16'hFFFF, "marker_edge_out");
        pix(16, 4, 16'hFFFF, "marker_top_out");
        pix(16, 5, 16'hF800, "marker_top_in");
        idle(3);

        // Shadowed vertical wall
        walls_v = 16'h0002;
        frames(1);
        pix(40, 10, 16'h0000, "wall_v_closed");
        walls_v = '0;
        pix(40, 10, 16'h0000, "wall_v_no_frame");
        pix_frame(40, 10, 16'h0000, "wall_v_frame_cycle");
        pix(40, 10, 16'hFFFF, "wall_v_opened");

        // Last vertical bit and a horizontal bit
        walls_v = 16'h8000;
        walls_h = 15'h0080;
        frames(1);
        pix(70, 55, 16'h0000, "wall_v_last");
        pix(47, 32, 16'h0000, "wall_h_closed");
        pix(18, 17, 16'hFFFF, "wall_h_open");
        walls_v = '0;
        walls_h = '0;
        frames(1);
        idle(3);

        // Blink: restart on move, toggle every 30 frames
        position = 6'd6;
        frames(1);
        pix(32, 24, 16'hF800, "blink_restart_on");
        frames(29);
        pix(32, 24, 16'hF800, "blink_29_on");
        frames(1);
        pix(32, 24, 16'hFFFF, "blink_30_off");
        frames(30);
        pix(32, 24, 16'hF800, "blink_60_on");
        frames(30);
        frames(10);
        pix(32, 24, 16'hFFFF, "blink_mid_off");

        // Move during OFF phase restarts ON with counter 0
        position = 6'd7;
        frames(1);
        pix(47, 24, 16'hF800, "move_on");
        pix(32, 24, 16'hFFFF, "old_cell_clear");
        frames(29);
        pix(47, 24, 16'hF800, "move_29_on");
        frames(1);
        pix(47, 24, 16'hFFFF, "move_30_off");

        // Out-of-range position and goal: no marker anywhere
        position = 6'd63;
        goal     = 6'd63;
        frames(1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix(17 + 15 * c, 9 + 15 * r, 16'hFFFF, $sformatf("no_marker_r%0dc%0d", r, c));
        idle(3);

        // Goal fill and marker priority over goal
        goal = 6'd19;
        frames(1);
        pix(77, 54, GOAL_COL, "goal_fill");
        pix(72, 54, 16'hFFFF, "goal_margin_out");
        position = 6'd19;
        frames(1);
        pix(77, 54, 16'hF800, "marker_over_goal");
        idle(3);

        // Reset mid-burst
        pix(50, 30, 16'hFFFF, "burst0");
        pix(50, 30, 16'hFFFF, "burst1");
        chk("burst_valid_before_reset", int'(pix_out_valid), 1);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        name_q.delete();
        #1;
        chk("reset_mid_valid", int'(pix_out_valid), 0);
        chk("reset_mid_data", int'(oled_data), 0);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        chk("post_reset_idle", int'(pix_out_valid), 0);

        // Shadows cleared: input walls ignored until frame_begin; marker back in cell 0
        walls_v = 16'h0002;
        pix(40, 10, 16'hFFFF, "post_reset_wall");
        pix(16, 8, 16'hF800, "post_reset_marker");

        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(posedge clock);
                waited++;
            end
            #1;
            chk("drain_queue_empty", exp_q.size(), 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
